cache_set_engine: RTL and testbench
===================================

Name: cache_set_engine

Overview:
- Parametrised, stateful successor to the split-L1 hit/LRU lookup logic.
- Owns the tag, MESI-state and LRU-age arrays for one cache, with WAYS and SETS configurable; the data and instruction caches become two instances.
- Accepts one trace command at a time over a valid/ready handshake and runs a multi-cycle lookup/update FSM.
- Reports hit, selected way, eviction and writeback information back to the trace-driven top level.

Parameters:
ADDR_W, 32, trace address width
OFFSET_W, 6, byte-offset bits (64 B lines)
INDEX_W, 14, set-index bits; SETS = 2**INDEX_W
WAYS, 8, associativity, power of two >= 2; 4 for instruction instance
TAG_W, ADDR_W-INDEX_W-OFFSET_W, derived, not overridable
AGE_W, $clog2(WAYS), derived

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  command present
req_ready  out  1  engine can accept (IDLE only)
req_cmd  in  4  trace op: 0 read, 1 write, 2 ifetch, 3 L2 invalidate, 4 snoop-read, 8 clear, 9 print
req_addr  in  ADDR_W  trace address
req_shared  in  1  another cache holds the line (selects S vs E on read/ifetch fill)
rsp_valid  out  1  one-cycle completion pulse
rsp_hit  out  1  tag match on a non-I line
rsp_way  out  AGE_W  way hit or filled
rsp_state  out  2  resulting MESI state of rsp_way: 0 I, 1 S, 2 E, 3 M
rsp_evict  out  1  valid line displaced by fill
rsp_evict_tag  out  TAG_W  tag of displaced line
rsp_evict_dirty  out  1  displaced line was M (writeback needed)

Behaviour:
- Reset (async, any state): FSM to IDLE; every line state I, tag 0, age[set][w]=w; all rsp_* outputs 0; req_ready=1 once reset deasserts.
- Ages within a set are always a permutation of 0..WAYS-1; 0 = MRU, WAYS-1 = LRU.
- FSM states: IDLE, LOOKUP, UPDATE, CLEAR.
- IDLE -> LOOKUP on req_valid&&req_ready; latch cmd, index, tag and shared. req_ready=0 outside IDLE.
- LOOKUP: compare the latched tag against all WAYS of the set; a hit needs state!=I; more than one match is impossible by construction (assertion).
- Victim on miss: lowest-index way in state I; otherwise the way with age==WAYS-1.
- UPDATE, per cmd:
  - read/ifetch hit: state unchanged except I is excluded; touch way.
  - read/ifetch miss: fill victim with the tag; state S if req_shared else E; touch.
  - write hit: state M; touch.
  - write miss: fill victim; state M; touch.
  - invalidate hit: state I; ages unchanged. Miss: no change.
  - snoop-read hit: M or E -> S; ages unchanged. Miss: no change.
  - print: no array change; rsp_hit=0.
  - Any other cmd value: treated as print.
- Touch of way w with old age a: every way with age<a increments; w gets 0; ages >a are unchanged.
- Eviction: rsp_evict=1 only when the filled victim's prior state !=I; rsp_evict_tag and rsp_evict_dirty come from the prior contents.
- rsp_valid pulses in UPDATE. Latency is acceptance edge + 2 cycles; FSM returns to IDLE the next cycle. Throughput is one command per 3 cycles.
- Clear (8): IDLE -> CLEAR. Walk index 0..SETS-1, one set per cycle, restoring reset contents. rsp_valid is asserted on the last set (latency SETS+1); rsp_hit=0, rsp_evict=0.
- Set-index counter wraps only at CLEAR exit. Reset mid-CLEAR forces full reset contents anyway.
- req_valid while busy: held off by the requester. Inputs other than req_valid are sampled only at acceptance.

Decomposition:
- Shared package my_struct_package: mesi_t enum, cmd_t enum (values above), and a parametrised line struct (tag, mesi, age) reused by the top-level trace driver.
- One sub-module, lru_age_update: combinational. Takes the age vector and the touched way; returns the new age vector and the victim index. Unit-tested separately.

Test Plan:
- Reset, then read 0x0000_0040 with req_shared=0 -> rsp_hit=0, rsp_way=0, rsp_state=E, rsp_evict=0, rsp_valid exactly 2 cycles after acceptance.
- Repeat the same read, then write 0x0000_0040 -> first rsp_hit=1, state E; second rsp_hit=1, state M, ways 1..7 ages unchanged.
- Fill set 1 with 9 distinct tags (WAYS=8), writing the first -> 9th access evicts way 0: rsp_evict=1, rsp_evict_dirty=1, rsp_evict_tag = first tag.
- Hit way 5 (age 3) in a full set -> ways aged 0..2 become 1..3, way 5 age 0, ages 4..7 unchanged; permutation holds.
- Snoop-read on an M line -> S. Invalidate on it -> I. Invalidate on an absent tag -> rsp_hit=0, no array change.
- Clear with INDEX_W=2 -> rsp_valid after 5 cycles; a subsequent read of any earlier address misses. Async reset asserted mid-lookup -> outputs 0 immediately, req_ready=1 after release.

Source files
------------

// File: rtl/my_struct_package.sv
// Shared types for the cache set engine and the trace driver:
// MESI states, trace commands, engine FSM states and a line record.
package my_struct_package;

  typedef enum logic [1:0] {
    MESI_I = 2'd0,
    MESI_S = 2'd1,
    MESI_E = 2'd2,
    MESI_M = 2'd3
  } mesi_t;

  typedef enum logic [3:0] {
    CMD_READ   = 4'd0,
    CMD_WRITE  = 4'd1,
    CMD_IFETCH = 4'd2,
    CMD_INVAL  = 4'd3,
    CMD_SNOOP  = 4'd4,
    CMD_CLEAR  = 4'd8,
    CMD_PRINT  = 4'd9
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_UPDATE,
    ST_CLEAR
  } eng_state_t;

  // Widest tag/age any instance uses; narrower
  // instances keep their values in the low bits.
  localparam int LINE_TAG_W = 32;
  localparam int LINE_AGE_W = 8;

  typedef struct packed {
    logic [LINE_TAG_W-1:0] tag;
    mesi_t                 mesi;
    logic [LINE_AGE_W-1:0] age;
  } line_t;

endpackage

// File: rtl/lru_age_update.sv
// Combinational LRU helper: ages the set for a touch of `way`
// and picks a victim (first invalid way, else the age WAYS-1 way).
// Ports: ages/invalid in, way in, ages_next/victim out.
module lru_age_update #(
  parameter  int WAYS  = 8,
  localparam int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS-1:0][AGE_W-1:0] ages,
  input  logic [WAYS-1:0]            invalid,
  input  logic [AGE_W-1:0]           way,
  output logic [WAYS-1:0][AGE_W-1:0] ages_next,
  output logic [AGE_W-1:0]           victim
);

  logic [AGE_W-1:0] old_age;
  logic             found;

  always_comb begin
    old_age   = ages[way];
    ages_next = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == way)
        ages_next[w] = '0;
      else if (ages[w] < old_age)
        ages_next[w] = ages[w] + AGE_W'(1);
    end
  end

  always_comb begin
    victim = '0;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && invalid[w]) begin
        victim = AGE_W'(w);
        found  = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages[w] == AGE_W'(WAYS-1))
          victim = AGE_W'(w);
      end
    end
  end

endmodule

// File: rtl/cache_set_engine.sv
// Tag/MESI/LRU store for one cache with a lookup/update FSM.
// Ports: req_* command handshake in, rsp_* one-cycle result out.
module cache_set_engine
  import my_struct_package::*;
#(
  parameter  int ADDR_W   = 32,
  parameter  int OFFSET_W = 6,
  parameter  int INDEX_W  = 14,
  parameter  int WAYS     = 8,
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int AGE_W    = $clog2(WAYS),
  localparam int SETS     = 2**INDEX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_shared,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AGE_W-1:0]  rsp_way,
  output logic [1:0]        rsp_state,
  output logic              rsp_evict,
  output logic [TAG_W-1:0]  rsp_evict_tag,
  output logic              rsp_evict_dirty
);

  logic [TAG_W-1:0] tags [SETS][WAYS];
  mesi_t            mesi [SETS][WAYS];
  logic [AGE_W-1:0] ages [SETS][WAYS];

  eng_state_t state_q, state_d;

  logic [3:0]         cmd_q;
  logic [INDEX_W-1:0] idx_q, clr_idx_q;
  logic [TAG_W-1:0]   tag_q;
  logic               shared_q;
  logic               hit_q;
  logic [AGE_W-1:0]   hway_q, vict_q;

  logic [WAYS-1:0][AGE_W-1:0] set_ages, ages_nx;
  logic [WAYS-1:0]            invalid, match;
  logic                       hit_c;
  logic [AGE_W-1:0]           hway_c, victim_c, tw;

  logic             we, touch, ev, r_hit;
  mesi_t            pm, new_mesi;
  logic [TAG_W-1:0] pt, new_tag;
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];
  assign req_ready = !rst && (state_q == ST_IDLE);
  assign hit_c = |match;
  // Hits update the hit way, misses fill the victim.
  assign tw = hit_q ? hway_q : vict_q;

  always_comb begin
    set_ages = '0;
    invalid  = '0;
    match    = '0;
    hway_c   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_ages[w] = ages[idx_q][w];
      invalid[w]  = (mesi[idx_q][w] == MESI_I);
      match[w]    = !invalid[w] && (tags[idx_q][w] == tag_q);
    end
    // Matches are one-hot, so OR-ing indices encodes the hit way.
    for (int w = 0; w < WAYS; w++)
      if (match[w]) hway_c = hway_c | AGE_W'(w);
  end

  lru_age_update #(.WAYS(WAYS)) u_lru (
    .ages      (set_ages),
    .invalid   (invalid),
    .way       (tw),
    .ages_next (ages_nx),
    .victim    (victim_c)
  );

  always_comb begin
    pm       = mesi[idx_q][tw];
    pt       = tags[idx_q][tw];
    we       = 1'b0;
    touch    = 1'b0;
    ev       = 1'b0;
    r_hit    = hit_q;
    new_mesi = pm;
    new_tag  = pt;
    case (cmd_q)
      CMD_READ, CMD_IFETCH: begin
        we    = 1'b1;
        touch = 1'b1;
        if (!hit_q) begin
          new_tag  = tag_q;
          new_mesi = shared_q ? MESI_S : MESI_E;
          ev       = (pm != MESI_I);
        end
      end
      CMD_WRITE: begin
        we       = 1'b1;
        touch    = 1'b1;
        new_mesi = MESI_M;
        if (!hit_q) begin
          new_tag = tag_q;
          ev      = (pm != MESI_I);
        end
      end
      CMD_INVAL: begin
        if (hit_q) begin
          we       = 1'b1;
          new_mesi = MESI_I;
        end
      end
      CMD_SNOOP: begin
        if (hit_q && (pm == MESI_M || pm == MESI_E)) begin
          we       = 1'b1;
          new_mesi = MESI_S;
        end
      end
      default: begin
        // Print, clear completion and unknown ops report nothing.
        r_hit    = 1'b0;
        new_mesi = MESI_I;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (req_valid)
          state_d = (req_cmd == CMD_CLEAR) ? ST_CLEAR : ST_LOOKUP;
      ST_LOOKUP: state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      ST_CLEAR:
        if (clr_idx_q == INDEX_W'(SETS-1)) state_d = ST_UPDATE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q           <= '0;
      idx_q           <= '0;
      tag_q           <= '0;
      shared_q        <= 1'b0;
      clr_idx_q       <= '0;
      hit_q           <= 1'b0;
      hway_q          <= '0;
      vict_q          <= '0;
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_way         <= '0;
      rsp_state       <= '0;
      rsp_evict       <= 1'b0;
      rsp_evict_tag   <= '0;
      rsp_evict_dirty <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (state_q == ST_IDLE && req_valid) begin
        cmd_q    <= req_cmd;
        idx_q    <= req_addr[OFFSET_W +: INDEX_W];
        tag_q    <= req_addr[ADDR_W-1 -: TAG_W];
        shared_q <= req_shared;
      end
      if (state_q == ST_LOOKUP) begin
        hit_q  <= hit_c;
        hway_q <= hway_c;
        vict_q <= victim_c;
      end
      // Counter wraps to zero as the last set is cleared.
      if (state_q == ST_CLEAR)
        clr_idx_q <= clr_idx_q + INDEX_W'(1);
      if (state_q == ST_UPDATE) begin
        rsp_valid       <= 1'b1;
        rsp_hit         <= r_hit;
        rsp_way         <= (cmd_q > CMD_SNOOP) ? '0 : tw;
        rsp_state       <= new_mesi;
        rsp_evict       <= ev;
        rsp_evict_tag   <= ev ? pt : '0;
        rsp_evict_dirty <= ev && (pm == MESI_M);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) begin
          tags[s][w] <= '0;
          mesi[s][w] <= MESI_I;
          ages[s][w] <= AGE_W'(w);
        end
    end else if (state_q == ST_CLEAR) begin
      for (int w = 0; w < WAYS; w++) begin
        tags[clr_idx_q][w] <= '0;
        mesi[clr_idx_q][w] <= MESI_I;
        ages[clr_idx_q][w] <= AGE_W'(w);
      end
    end else if (state_q == ST_UPDATE) begin
      if (we) begin
        tags[idx_q][tw] <= new_tag;
        mesi[idx_q][tw] <= new_mesi;
      end
      if (touch)
        for (int w = 0; w < WAYS; w++)
          ages[idx_q][w] <= ages_nx[w];
    end
  end

  a_one_match: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == ST_LOOKUP) |-> $onehot0(match));

endmodule

// File: tb/tb_cache_set_engine.sv
// Directed scoreboard bench for cache_set_engine (8 ways, 4 sets).
// Ports: drives req_*, checks rsp_* and the set-1 age array.
module tb_cache_set_engine;

  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 6;
  localparam int INDEX_W  = 2;
  localparam int WAYS     = 8;
  localparam int TAG_W    = 24;
  localparam int AGE_W    = 3;

  localparam logic [1:0] MI = 2'd0;
  localparam logic [1:0] MS = 2'd1;
  localparam logic [1:0] ME = 2'd2;
  localparam logic [1:0] MM = 2'd3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_cmd = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              req_shared = 1'b0;
  logic              rsp_valid;
  logic              rsp_hit;
  logic [AGE_W-1:0]  rsp_way;
  logic [1:0]        rsp_state;
  logic              rsp_evict;
  logic [TAG_W-1:0]  rsp_evict_tag;
  logic              rsp_evict_dirty;

  always #5 clk = ~clk;

  cache_set_engine #(
    .ADDR_W   (ADDR_W),
    .OFFSET_W (OFFSET_W),
    .INDEX_W  (INDEX_W),
    .WAYS     (WAYS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_cmd         (req_cmd),
    .req_addr        (req_addr),
    .req_shared      (req_shared),
    .rsp_valid       (rsp_valid),
    .rsp_hit         (rsp_hit),
    .rsp_way         (rsp_way),
    .rsp_state       (rsp_state),
    .rsp_evict       (rsp_evict),
    .rsp_evict_tag   (rsp_evict_tag),
    .rsp_evict_dirty (rsp_evict_dirty)
  );

  typedef struct {
    logic             hit;
    logic [2:0]       way;
    logic [1:0]       st;
    logic             ev;
    logic [TAG_W-1:0] etag;
    logic             ed;
    bit               cws;
    int               lat;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] ea [8];

  task automatic chk(input string nm, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, want);
    end
  endtask

  function automatic exp_t mk(logic h, logic [2:0] w, logic [1:0] s,
                              logic e, logic [TAG_W-1:0] t, logic d,
                              bit cws, int lat);
    exp_t x;
    x.hit = h; x.way = w; x.st = s; x.ev = e;
    x.etag = t; x.ed = d; x.cws = cws; x.lat = lat;
    return x;
  endfunction

  function automatic logic [31:0] a1(int t);
    logic [23:0] tg;
    tg = 24'(t);
    return {tg, 2'b01, 6'h15};
  endfunction

  task automatic send(input string nm, input logic [3:0] c,
                      input logic [31:0] a, input logic sh,
                      input exp_t e);
    exp_t x;
    int   n;
    sb.push_back(e);
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, ".rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_cmd = c;
    req_addr = a;     req_shared = sh;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_cmd = 4'hF;
    req_addr = '1;    req_shared = ~sh;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    x = sb.pop_front();
    chk({nm, ".lat"}, 32'(n), 32'(x.lat));
    chk({nm, ".hit"}, 32'(rsp_hit), 32'(x.hit));
    if (x.cws) begin
      chk({nm, ".way"}, 32'(rsp_way), 32'(x.way));
      chk({nm, ".st"}, 32'(rsp_state), 32'(x.st));
    end
    chk({nm, ".ev"}, 32'(rsp_evict), 32'(x.ev));
    chk({nm, ".etag"}, 32'(rsp_evict_tag), 32'(x.etag));
    chk({nm, ".edty"}, 32'(rsp_evict_dirty), 32'(x.ed));
    @(posedge clk);
    #1;
    chk({nm, ".pulse"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic chk_ages(input string nm);
    logic [7:0] seen;
    logic [2:0] g;
    seen = '0;
    for (int w = 0; w < WAYS; w++) begin
      g = dut.ages[1][w];
      seen[g] = 1'b1;
      chk($sformatf("%s.age%0d", nm, w), 32'(g), 32'(ea[w]));
    end
    chk({nm, ".perm"}, 32'(seen), 32'hFF);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.hit", 32'(rsp_hit), 32'd0);
    chk("rst.st", 32'(rsp_state), 32'd0);
    chk("rst.ev", 32'(rsp_evict), 32'd0);

    send("rd0", 4'd0, 32'h40, 1'b0, mk(0, 0, ME, 0, 0, 0, 1, 2));
    send("rd0b", 4'd0, 32'h40, 1'b0, mk(1, 0, ME, 0, 0, 0, 1, 2));
    send("wr0", 4'd1, 32'h40, 1'b0, mk(1, 0, MM, 0, 0, 0, 1, 2));
    ea = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    chk_ages("wr0");

    for (int k = 1; k < 8; k++)
      send($sformatf("fill%0d", k), (k == 3) ? 4'd2 : 4'd0,
           a1(k), k[0],
           mk(0, 3'(k), k[0] ? MS : ME, 0, 0, 0, 1, 2));

    send("evict", 4'd0, a1(8), 1'b0, mk(0, 0, ME, 1, 0, 1, 1, 2));
    ea = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    chk_ages("evict");

    send("hit5", 4'd0, a1(5), 1'b0, mk(1, 5, MS, 0, 0, 0, 1, 2));
    ea = '{3'd1, 3'd7, 3'd6, 3'd5, 3'd4, 3'd0, 3'd3, 3'd2};
    chk_ages("hit5");

    send("wr5", 4'd1, a1(5), 1'b0, mk(1, 5, MM, 0, 0, 0, 1, 2));
    send("hit2", 4'd0, a1(2), 1'b1, mk(1, 2, ME, 0, 0, 0, 1, 2));
    ea = '{3'd2, 3'd7, 3'd0, 3'd6, 3'd5, 3'd1, 3'd4, 3'd3};
    chk_ages("hit2");

    send("snp5", 4'd4, a1(5), 1'b0, mk(1, 5, MS, 0, 0, 0, 1, 2));
    chk_ages("snp5");
    send("inv5", 4'd3, a1(5), 1'b0, mk(1, 5, MI, 0, 0, 0, 1, 2));
    chk_ages("inv5");
    send("invx", 4'd3, a1(99), 1'b0, mk(0, 0, MI, 0, 0, 0, 0, 2));
    chk_ages("invx");
    chk("invx.m2", 32'(dut.mesi[1][2]), 32'(ME));
    send("snpx", 4'd4, a1(98), 1'b0, mk(0, 0, MI, 0, 0, 0, 0, 2));

    send("fillI", 4'd0, a1(119), 1'b0, mk(0, 5, ME, 0, 0, 0, 1, 2));
    ea = '{3'd2, 3'd7, 3'd1, 3'd6, 3'd5, 3'd0, 3'd4, 3'd3};
    chk_ages("fillI");
    send("wrmiss", 4'd1, a1(85), 1'b0, mk(0, 1, MM, 1, 1, 0, 1, 2));
    ea = '{3'd3, 3'd0, 3'd2, 3'd7, 3'd6, 3'd1, 3'd5, 3'd4};
    chk_ages("wrmiss");

    send("print", 4'd9, a1(85), 1'b0, mk(0, 0, MI, 0, 0, 0, 1, 2));
    send("cmd5", 4'd5, a1(85), 1'b0, mk(0, 0, MI, 0, 0, 0, 1, 2));
    send("clear", 4'd8, a1(0), 1'b0, mk(0, 0, MI, 0, 0, 0, 1, 5));
    ea = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    chk_ages("clear");
    send("pclr8", 4'd0, a1(8), 1'b0, mk(0, 0, ME, 0, 0, 0, 1, 2));
    send("pclr85", 4'd0, a1(85), 1'b1, mk(0, 1, MS, 0, 0, 0, 1, 2));

    @(negedge clk);
    req_valid = 1'b1; req_cmd = 4'd0;
    req_addr = a1(8); req_shared = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("mid.pre", 32'(rsp_way), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid.way", 32'(rsp_way), 32'd0);
    chk("mid.st", 32'(rsp_state), 32'd0);
    chk("mid.valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid.ready", 32'(req_ready), 32'd1);
    send("postrst", 4'd0, a1(8), 1'b0, mk(0, 0, ME, 0, 0, 0, 1, 2));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
